// File: rtl/hazard_forwarding_unit.sv
// Operand-forwarding selects and load-use stall/flush control for the ID stage; optional HAZARD_STALL_ONLY_EN = interlock without forwarding.
// Latency: outputs are combinational from tracked EX/MEM/WB state and ID inputs (valid zero cycles after each edge).
// Backpressure: a stall drops pc_le/ifid_le and injects a NOP bubble into EX; a pending stall suppresses the branch flush.
module hazard_forwarding_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             branch_taken,
  output logic [1:0]       sel_pa,
  output logic [1:0]       sel_pb,
  output logic [1:0]       sel_pd,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             nop_s,
  output logic             ifid_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] PC_R = REG_W'(PC_REG);

  // Shadow of the EX/MEM/WB destination tracking
  logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_rf_e_q, mem_rf_e_q, wb_rf_e_q;
  logic             ex_load_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [REG_W-1:0] ex_rd_d;
  logic             ex_rf_e_d, ex_load_d;
  logic [CNT_W-1:0] stall_cnt_d;

  logic ex_rn_m, ex_rm_m, ex_rd_m;
  logic mem_rn_m, mem_rm_m, mem_rd_m;
  logic wb_rn_m, wb_rm_m, wb_rd_m;
  logic ex_any, mem_any, wb_any;
  logic stall;

  // A stage supplies a source only if it writes that register; the PC register is never forwarded.
  function automatic logic match(input logic rf_e, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] src, input logic use_src);
    return rf_e & (rd == src) & use_src & (src != PC_R);
  endfunction

  // Per-stage, per-operand dependency detection
  always_comb begin
    ex_rn_m  = match(ex_rf_e_q,  ex_rd_q,  id_rn, id_use_rn);
    ex_rm_m  = match(ex_rf_e_q,  ex_rd_q,  id_rm, id_use_rm);
    ex_rd_m  = match(ex_rf_e_q,  ex_rd_q,  id_rd, id_use_rd);
    mem_rn_m = match(mem_rf_e_q, mem_rd_q, id_rn, id_use_rn);
    mem_rm_m = match(mem_rf_e_q, mem_rd_q, id_rm, id_use_rm);
    mem_rd_m = match(mem_rf_e_q, mem_rd_q, id_rd, id_use_rd);
    wb_rn_m  = match(wb_rf_e_q,  wb_rd_q,  id_rn, id_use_rn);
    wb_rm_m  = match(wb_rf_e_q,  wb_rd_q,  id_rm, id_use_rm);
    wb_rd_m  = match(wb_rf_e_q,  wb_rd_q,  id_rd, id_use_rd);
    ex_any   = ex_rn_m  | ex_rm_m  | ex_rd_m;
    mem_any  = mem_rn_m | mem_rm_m | mem_rd_m;
    wb_any   = wb_rn_m  | wb_rm_m  | wb_rd_m;
  end

`ifdef HAZARD_STALL_ONLY_EN
  // Full interlock: hold ID until every producer has retired from WB; operands always come from the RF.
  always_comb begin
    stall  = ex_any | mem_any | wb_any | (ex_load_q & 1'b0);
    sel_pa = 2'b00;
    sel_pb = 2'b00;
    sel_pd = 2'b00;
  end
`else
  // Youngest producer wins; an operand waiting on a load in EX is don't-care while stalled, so it reads the RF.
  function automatic logic [1:0] pick(input logic ex_m, input logic mem_m,
                                      input logic wb_m, input logic stl);
    if (ex_m)       return stl ? 2'b00 : 2'b01;
    else if (mem_m) return 2'b10;
    else if (wb_m)  return 2'b11;
    else            return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time; it costs exactly one bubble.
  always_comb begin
    stall  = ex_load_q & ex_rf_e_q & ex_any;
    sel_pa = pick(ex_rn_m, mem_rn_m, wb_rn_m, stall);
    sel_pb = pick(ex_rm_m, mem_rm_m, wb_rm_m, stall);
    sel_pd = pick(ex_rd_m, mem_rd_m, wb_rd_m, stall);
  end
`endif

  // Stall/flush controls and next-state of the EX slot and counter
  always_comb begin
    pc_le       = ~stall;
    ifid_le     = ~stall;
    nop_s       = stall;
    ifid_clr    = branch_taken & ~stall;
    stall_cnt   = stall_cnt_q;
    ex_rd_d     = id_rd;
    ex_rf_e_d   = id_rf_e & ~stall;
    ex_load_d   = id_load & ~stall;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Advance the tracking pipeline one stage per clock; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd_q     <= '0;
      ex_rf_e_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_rf_e_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_rf_e_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_rf_e_q   <= ex_rf_e_d;
      ex_load_q   <= ex_load_d;
      mem_rd_q    <= ex_rd_q;
      mem_rf_e_q  <= ex_rf_e_q;
      wb_rd_q     <= mem_rd_q;
      wb_rf_e_q   <= mem_rf_e_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: scripted instruction sequences with expected outputs queued per cycle.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Also covers the HAZARD_STALL_ONLY_EN build when that macro is defined.
module tb_hazard_forwarding_unit;

  typedef struct packed {
    logic [3:0] rn, rm, rd;
    logic urn, urm, urd, rfe, ld, br;
  } stim_t;

  typedef struct packed {
    logic [1:0]  pa, pb, pd;
    logic        pc_le, ifid_le, nop_s, clr;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] id_rn, id_rm, id_rd;
  logic id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load, branch_taken;
  logic [1:0] sel_pa, sel_pb, sel_pd;
  logic pc_le, ifid_le, nop_s, ifid_clr;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  hazard_forwarding_unit #(.REG_W(4), .PC_REG(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_e(id_rf_e), .id_load(id_load), .branch_taken(branch_taken),
    .sel_pa(sel_pa), .sel_pb(sel_pb), .sel_pd(sel_pd),
    .pc_le(pc_le), .ifid_le(ifid_le), .nop_s(nop_s), .ifid_clr(ifid_clr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(int rn, int rm, int rd, int urn, int urm, int urd,
                               int rfe, int ld, int br);
    stim_t s;
    s.rn = 4'(rn); s.rm = 4'(rm); s.rd = 4'(rd);
    s.urn = (urn != 0); s.urm = (urm != 0); s.urd = (urd != 0);
    s.rfe = (rfe != 0); s.ld = (ld != 0); s.br = (br != 0);
    return s;
  endfunction

  function automatic exp_t mk(int pa, int pb, int pd, int pc, int il, int nop, int clr, int c);
    exp_t e;
    e.pa = 2'(pa); e.pb = 2'(pb); e.pd = 2'(pd);
    e.pc_le = (pc != 0); e.ifid_le = (il != 0); e.nop_s = (nop != 0); e.clr = (clr != 0);
    e.cnt = 16'(c);
    return e;
  endfunction

  function automatic exp_t idle(int c);
    return mk(0, 0, 0, 1, 1, 0, 0, c);
  endfunction

  function automatic exp_t stl(int c);
    return mk(0, 0, 0, 0, 0, 1, 0, c);
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = {sel_pa, sel_pb, sel_pd, pc_le, ifid_le, nop_s, ifid_clr, stall_cnt};
    return o;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk); #1;
    id_rn = s.rn; id_rm = s.rm; id_rd = s.rd;
    id_use_rn = s.urn; id_use_rm = s.urm; id_use_rd = s.urd;
    id_rf_e = s.rfe; id_load = s.ld; branch_taken = s.br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apply_idle_now();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_idle_now();
    id_rn = '0; id_rm = '0; id_rd = '0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
    id_rf_e = 0; id_load = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    stim_t s[5]; exp_t e[5]; exp_t got, want; int n;
    do_reset();
    s[0] = st(0, 0, 5, 0, 0, 0, 1, 1, 0); e[0] = idle(0);   // LDR R5
    s[1] = st(5, 5, 6, 1, 1, 0, 1, 0, 0); e[1] = stl(0);    // ADD R6,R5,R5
    s[2] = s[1];
`ifdef HAZARD_STALL_ONLY_EN
    e[2] = stl(1);
    n = 3;
`else
    e[2] = mk(2, 2, 0, 1, 1, 0, 0, 1);
    s[3] = s[0];                           e[3] = idle(1);
    s[4] = s[1];                           e[4] = stl(1);
    n = 5;
`endif
    for (int i = 0; i < n; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_pre step %0d: got %h expected %h", i, got, want);
      end
    end
    // async reset in the middle of a stall, with the dependent instruction still in ID
    #1 reset = 1'b1;
    sb.push_back(idle(0));
    #1;
    got = observe(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", got, want);
    end
    @(posedge clk); #1;
    sb.push_back(idle(0));
    got = observe(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_held: got %h expected %h", got, want);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pc_reg();
    stim_t s[3]; exp_t e[3]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 15, 0, 0, 0, 1, 1, 0);   e[0] = idle(0);  // LDR R15
    s[1] = st(15, 15, 15, 1, 1, 1, 0, 0, 0); e[1] = idle(0);  // reads R15 everywhere
    s[2] = s[1];                             e[2] = idle(0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL pc_reg step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask

`ifdef HAZARD_STALL_ONLY_EN
  task automatic test_stall_only();
    stim_t s[6]; exp_t e[6]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 1, 0, 0, 0, 1, 0, 0); e[0] = idle(0);  // ADD R1
    s[1] = st(1, 0, 2, 1, 0, 0, 1, 0, 0); e[1] = stl(0);   // SUB R2,R1 : EX match
    s[2] = s[1];                          e[2] = stl(1);   // MEM match
    s[3] = s[1];                          e[3] = stl(2);   // WB match
    s[4] = s[1];                          e[4] = idle(3);  // producer retired
    s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = idle(3);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL stall_only step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask
`else
  task automatic test_forward();
    stim_t s[5]; exp_t e[5]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 1, 0, 0, 0, 1, 0, 0); e[0] = idle(0);                  // ADD R1
    s[1] = st(1, 3, 2, 1, 1, 0, 1, 0, 0); e[1] = mk(1, 0, 0, 1, 1, 0, 0, 0); // SUB R2,R1,R3
    s[2] = st(1, 0, 7, 1, 0, 0, 0, 0, 0); e[2] = mk(2, 0, 0, 1, 1, 0, 0, 0);
    s[3] = s[2];                          e[3] = mk(3, 0, 0, 1, 1, 0, 0, 0);
    s[4] = st(1, 0, 2, 1, 0, 1, 0, 0, 0); e[4] = mk(0, 0, 3, 1, 1, 0, 0, 0); // store R2 from WB
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL forward step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s[4]; exp_t e[4]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 1, 0, 0, 0, 1, 0, 0); e[0] = idle(0);                  // MOV R1
    s[1] = s[0];                          e[1] = idle(0);                  // ADD R1
    s[2] = st(1, 1, 9, 1, 1, 0, 0, 0, 0); e[2] = mk(1, 1, 0, 1, 1, 0, 0, 0); // EX over MEM
    s[3] = st(1, 0, 9, 1, 0, 0, 0, 0, 0); e[3] = mk(2, 0, 0, 1, 1, 0, 0, 0); // MEM over WB
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL priority step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[6]; exp_t e[6]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 5, 0, 0, 0, 1, 1, 0); e[0] = idle(0);                  // LDR R5
    s[1] = st(5, 5, 6, 1, 1, 0, 1, 0, 0); e[1] = stl(0);                   // ADD R6,R5,R5
    s[2] = s[1];                          e[2] = mk(2, 2, 0, 1, 1, 0, 0, 1);
    s[3] = st(0, 0, 4, 0, 0, 0, 1, 1, 0); e[3] = idle(1);                  // LDR R4
    s[4] = st(0, 0, 4, 0, 0, 1, 0, 0, 0); e[4] = stl(1);                   // STR R4
    s[5] = s[4];                          e[5] = mk(0, 0, 2, 1, 1, 0, 0, 2);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[5]; exp_t e[5]; exp_t got, want;
    do_reset();
    s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = mk(0, 0, 0, 1, 1, 0, 1, 0);
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = idle(0);
    s[2] = st(0, 0, 5, 0, 0, 0, 1, 1, 0); e[2] = idle(0);                  // LDR R5
    s[3] = st(5, 0, 6, 1, 0, 0, 1, 0, 1); e[3] = stl(0);                   // taken branch blocked
    s[4] = s[3];                          e[4] = mk(2, 0, 0, 1, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL branch step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    apply_idle_now();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
`ifdef HAZARD_STALL_ONLY_EN
    test_stall_only();
`else
    test_forward();
    test_priority();
    test_load_use();
    test_branch();
`endif
    test_pc_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_forwarding_unit.md
Name: hazard_forwarding_unit

Overview:
Generates the select lines for the PA/PB/PD operand muxes in ID (register file vs EX/MEM/WB forwarding paths). Also generates the stall controls: PC enable, IF/ID load enable, and the NOP-select S of the control-signal mux. It is the driving end of the forwarding/stall interface that the datapath muxes and pipeline registers consume. It tracks destination register, RF write enable and load flag of the instructions in EX, MEM and WB internally, so it needs only ID-stage information plus the branch decision.

Parameters:
REG_W, 4, register-number width (I19-I16, I3-I0, I15-I12 fields)
PC_REG, 15, register number never forwarded or stalled on (read via PC path)
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all internal state
id_rn  in  REG_W  ID source for PA (I19-I16)
id_rm  in  REG_W  ID source for PB (I3-I0)
id_rd  in  REG_W  ID source for PD / destination (I15-I12)
id_use_rn  in  1  ID instruction reads Rn
id_use_rm  in  1  ID instruction reads Rm
id_use_rd  in  1  ID instruction reads Rd (store data)
id_rf_e  in  1  ID instruction writes Rd (control unit RF_E)
id_load  in  1  ID instruction is a load (ID_LOAD)
branch_taken  in  1  condition handler: branch/BL taken this cycle
sel_pa  out  2  00 RF, 01 EX, 10 MEM, 11 WB
sel_pb  out  2  same encoding
sel_pd  out  2  same encoding
pc_le  out  1  PC load enable
ifid_le  out  1  IF/ID load enable
nop_s  out  1  S of control mux; 1 = inject NOP into ID/EX
ifid_clr  out  1  flush IF/ID (load NOP) on taken branch
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Internal shift pipeline: ex_{rd,rf_e,load} -> mem_{rd,rf_e} -> wb_{rd,rf_e}, one stage per clk.
- At each posedge the EX slot loads id_rd/id_rf_e/id_load gated by ~nop_s. When nop_s=1, rf_e=0 and load=0 are loaded (bubble). MEM takes EX and WB takes MEM unconditionally.
- Match(stage,src) = stage_rf_e & (stage_rd == src) & use_src & (src != PC_REG).
- Select per operand is combinational, with priority EX > MEM > WB > RF (youngest wins when several stages match).
- Load-use: stall = ex_load & ex_rf_e & (Match(EX,rn)|Match(EX,rm)|Match(EX,rd)).
- During stall: pc_le=0, ifid_le=0, nop_s=1. The select for the EX-matched operand is don't-care; drive it 00.
- Stall lasts exactly 1 cycle. The next cycle the load is in MEM and is forwarded via 10.
- ifid_clr = branch_taken & ~stall. Stall has priority; the branch stays in ID and is re-evaluated the next cycle.
- Outputs are combinational from internal state and ID inputs. Latency from a posedge to valid outputs is zero cycles after that edge.
- stall_cnt increments on every posedge with stall=1 and saturates at all-ones (no wrap).
- Reset (async, any time, including mid-stall): all stage rf_e/load/rd = 0, stall_cnt = 0.
- After reset, with no ID uses: sel_* = 00, pc_le=1, ifid_le=1, nop_s=0, ifid_clr=0.
- Reset overrides a pending stall immediately.
- Rd == PC_REG writes are tracked but never matched.

Optional Feature:
HAZARD_STALL_ONLY_EN:
- Defined: forwarding is disabled and sel_* is tied to 00. stall = any Match in EX, MEM or WB. The stall holds until the producer leaves WB (up to 3 cycles). ifid_clr is suppressed by stall as above.
- Undefined: forwarding and single-cycle load-use stall, as specified in Behaviour.

Test Plan:
1. Reset asserted mid-stall (ex_load=1, match) -> immediately sel_*=00, pc_le=1, nop_s=0, stall_cnt=0.
2. ADD R1 then SUB R2,R1,R3 next cycle (id_rn=1, use_rn=1) -> sel_pa=01, no stall. Same source two and three instructions later -> 10, then 11.
3. R1 written in EX (ADD) and in MEM (earlier MOV), ID reads R1 -> sel_pa=01 (EX priority).
4. LDR R5 then ADD R6,R5,R5 -> one cycle with pc_le=0, ifid_le=0, nop_s=1. Next cycle sel_pa=sel_pb=10. stall_cnt=1.
5. branch_taken=1 with no hazard -> ifid_clr=1 for one cycle. branch_taken=1 during a load-use stall -> ifid_clr=0 that cycle, then 1 the following cycle.
6. Source register 15 with EX rd=15, rf_e=1 -> sel=00, no stall. With HAZARD_STALL_ONLY_EN defined, test 2 stalls 3 cycles and sel_pa stays 00.
